// File: rtl/spi_xip_pkg.sv
// rtl/spi_xip_pkg.sv - shared constants and FSM state type for the SPI XIP APB bridge
package spi_xip_pkg;

  // spi_top register offsets on the Wishbone side
  localparam logic [4:0] OFS_RX0  = 5'h00;
  localparam logic [4:0] OFS_TX1  = 5'h04;
  localparam logic [4:0] OFS_CTRL = 5'h10;
  localparam logic [4:0] OFS_DIV  = 5'h14;
  localparam logic [4:0] OFS_SS   = 5'h18;

  // CTRL register fields
  localparam int         CTRL_GO_BSY   = 8;
  localparam int         CTRL_TX_NEG   = 10;
  localparam logic [6:0] CTRL_LEN_XIP  = 7'd64;

  // one 64-bit transfer: 8-bit opcode, 24-bit address, 32 bits of read data
  localparam logic [31:0] CTRL_XIP = (32'd1 << CTRL_GO_BSY) | (32'd1 << CTRL_TX_NEG)
                                   | {25'd0, CTRL_LEN_XIP};

  typedef enum logic [3:0] {
    S_IDLE,
    S_PASS,
    S_WR_TX1,
    S_WR_DIV,
    S_WR_SS,
    S_WR_CTRL,
    S_POLL,
    S_RD_RX,
    S_WR_SSCLR,
    S_RESP
  } state_t;

endpackage

// File: rtl/spi_xip_apb_bridge_if.sv
// rtl/spi_xip_apb_bridge_if.sv - APB slave and Wishbone master signal bundle for the bridge
interface spi_xip_apb_bridge_if;

  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  // bridge view: APB slave facing the CPU, Wishbone master facing spi_top
  modport slave (
    input  in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  // environment view: APB requester plus spi_top register file
  modport master (
    output in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/spi_xip_wb_master.sv
// rtl/spi_xip_wb_master.sv - single outstanding Wishbone transaction engine
module spi_xip_wb_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  adr,
  input  logic [31:0] dat,
  input  logic [3:0]  sel,
  input  logic        we,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  // completion is visible to the caller in the ack/err cycle itself
  assign done  = wb_cyc_o & (wb_ack_i | wb_err_i);
  assign err   = wb_cyc_o & wb_err_i;
  assign rdata = wb_dat_i;

  // launch on req, hold the bus stable until ack/err, drop everything the cycle after
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else if (wb_cyc_o) begin
      if (wb_ack_i || wb_err_i) begin
        wb_adr_o <= '0;
        wb_dat_o <= '0;
        wb_sel_o <= '0;
        wb_we_o  <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end
    end else if (req) begin
      wb_adr_o <= adr;
      wb_dat_o <= dat;
      wb_sel_o <= sel;
      wb_we_o  <= we;
      wb_stb_o <= 1'b1;
      wb_cyc_o <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_xip_apb_bridge.sv
// rtl/spi_xip_apb_bridge.sv - APB to spi_top bridge with register pass-through and XIP flash window
module spi_xip_apb_bridge
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
  parameter logic [31:0] SPI_END    = 32'h1000_1fff,
  parameter logic [7:0]  FLASH_CMD  = 8'h03,
  parameter int          SS_IDX     = 0,
  parameter logic [15:0] CLK_DIV    = 16'd1,
  parameter int          POLL_MAX   = 1024
) (
  input logic                  clock,
  input logic                  reset,
  spi_xip_apb_bridge_if.slave  bus
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  state_t          state;
  logic            issued;
  logic            req;
  logic [PCW-1:0]  poll_cnt;
  logic [23:0]     addr_q;
  logic [31:0]     pass_dat;
  logic [3:0]      pass_sel;
  logic            pass_we;
  logic [31:0]     rx_q;
  logic            err_q;
  logic            pready;
  logic [31:0]     prdata;
  logic            pslverr;

  logic [4:0]      cmd_adr;
  logic [31:0]     cmd_dat;
  logic [3:0]      cmd_sel;
  logic            cmd_we;
  logic            wb_done;
  logic            wb_err;
  logic [31:0]     wb_rdata;

  logic            in_b;
  logic            in_f;

  assign in_b = (bus.in_paddr >= SPI_BASE) && (bus.in_paddr <= SPI_END);
  assign in_f = (bus.in_paddr >= FLASH_BASE) && (bus.in_paddr <= FLASH_END);

  assign bus.in_pready  = pready;
  assign bus.in_prdata  = prdata;
  assign bus.in_pslverr = pslverr;

  // Wishbone command for the step the FSM is currently sitting in
  always_comb begin
    cmd_adr = '0;
    cmd_dat = '0;
    cmd_sel = 4'hf;
    cmd_we  = 1'b1;
    case (state)
      S_PASS: begin
        cmd_adr = addr_q[4:0];
        cmd_dat = pass_dat;
        cmd_sel = pass_sel;
        cmd_we  = pass_we;
      end
      S_WR_TX1: begin
        cmd_adr = OFS_TX1;
        cmd_dat = {FLASH_CMD, addr_q};
      end
      S_WR_DIV: begin
        cmd_adr = OFS_DIV;
        cmd_dat = {16'd0, CLK_DIV};
      end
      S_WR_SS: begin
        cmd_adr = OFS_SS;
        cmd_dat = 32'd1 << SS_IDX;
      end
      S_WR_CTRL: begin
        cmd_adr = OFS_CTRL;
        cmd_dat = CTRL_XIP;
      end
      S_POLL: begin
        cmd_adr = OFS_CTRL;
        cmd_we  = 1'b0;
      end
      S_RD_RX: begin
        cmd_adr = OFS_RX0;
        cmd_we  = 1'b0;
      end
      S_WR_SSCLR: begin
        cmd_adr = OFS_SS;
        cmd_dat = '0;
      end
      default: begin
        cmd_adr = '0;
        cmd_dat = '0;
      end
    endcase
  end

  spi_xip_wb_master u_wb_master (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .adr      (cmd_adr),
    .dat      (cmd_dat),
    .sel      (cmd_sel),
    .we       (cmd_we),
    .done     (wb_done),
    .err      (wb_err),
    .rdata    (wb_rdata),
    .wb_adr_o (bus.wb_adr_o),
    .wb_dat_o (bus.wb_dat_o),
    .wb_sel_o (bus.wb_sel_o),
    .wb_we_o  (bus.wb_we_o),
    .wb_stb_o (bus.wb_stb_o),
    .wb_cyc_o (bus.wb_cyc_o),
    .wb_dat_i (bus.wb_dat_i),
    .wb_ack_i (bus.wb_ack_i),
    .wb_err_i (bus.wb_err_i)
  );

  // control FSM: decode in IDLE, then one WB transaction per step, every error path via SS clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      issued   <= 1'b0;
      req      <= 1'b0;
      poll_cnt <= '0;
      addr_q   <= '0;
      pass_dat <= '0;
      pass_sel <= '0;
      pass_we  <= 1'b0;
      rx_q     <= '0;
      err_q    <= 1'b0;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else begin
      req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_psel && bus.in_penable) begin
            addr_q   <= bus.in_paddr[23:0];
            pass_dat <= bus.in_pwdata;
            pass_sel <= bus.in_pstrb;
            pass_we  <= bus.in_pwrite;
            poll_cnt <= '0;
            rx_q     <= '0;
            err_q    <= 1'b0;
            issued   <= 1'b0;
            if (in_b) begin
              state <= S_PASS;
            end else if (in_f && !bus.in_pwrite) begin
              state <= S_WR_TX1;
            end else begin
              pready  <= 1'b1;
              pslverr <= 1'b1;
              state   <= S_RESP;
            end
          end
        end
        S_RESP: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          state   <= S_IDLE;
        end
        default: begin
          if (!issued) begin
            req    <= 1'b1;
            issued <= 1'b1;
          end else if (wb_done) begin
            issued <= 1'b0;
            if (wb_err) err_q <= 1'b1;
            case (state)
              S_PASS: begin
                prdata  <= wb_rdata;
                pslverr <= wb_err;
                pready  <= 1'b1;
                state   <= S_RESP;
              end
              S_WR_TX1:  state <= wb_err ? S_WR_SSCLR : S_WR_DIV;
              S_WR_DIV:  state <= wb_err ? S_WR_SSCLR : S_WR_SS;
              S_WR_SS:   state <= wb_err ? S_WR_SSCLR : S_WR_CTRL;
              S_WR_CTRL: state <= wb_err ? S_WR_SSCLR : S_POLL;
              S_POLL: begin
                if (wb_err) begin
                  state <= S_WR_SSCLR;
                end else if (!wb_rdata[CTRL_GO_BSY]) begin
                  state <= S_RD_RX;
                end else if (poll_cnt == POLL_LAST) begin
                  poll_cnt <= poll_cnt + 1'b1;
                  err_q    <= 1'b1;
                  state    <= S_WR_SSCLR;
                end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                end
              end
              S_RD_RX: begin
                rx_q  <= wb_rdata;
                state <= S_WR_SSCLR;
              end
              S_WR_SSCLR: begin
                pready  <= 1'b1;
                pslverr <= err_q | wb_err;
                prdata  <= (err_q | wb_err) ? 32'd0
                         : {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                state   <= S_RESP;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xip_apb_bridge.sv
// tb/tb_spi_xip_apb_bridge.sv - randomized self-checking bench for spi_xip_apb_bridge
module tb_spi_xip_apb_bridge;

  localparam int PMAX = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_xip_apb_bridge_if bus();

  spi_xip_apb_bridge #(.POLL_MAX(PMAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int unsigned cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // spi_top / flash behaviour seen by the responder
  bit          pass_mode;
  int          busy_left;
  int          err_at;
  int          txn_idx;
  logic [31:0] rx_word;
  logic [31:0] pass_rd;
  int unsigned last_ack_cycle;
  logic [41:0] log_q[$];

  // expected outcome of the current access
  logic [41:0] exp_q[$];
  bit          exp_err;
  bit          exp_rd_valid;
  logic [31:0] exp_rd;
  bit          exp_no_wb;

  function automatic logic [41:0] enc(input bit we, input logic [4:0] a, input logic [3:0] s,
                                      input logic [31:0] d);
    return {we, a, s, (we ? d : 32'h0)};
  endfunction

  function automatic bit win_b(input logic [31:0] a);
    return (a >= 32'h1000_1000) && (a <= 32'h1000_1fff);
  endfunction

  function automatic bit win_f(input logic [31:0] a);
    return (a >= 32'h3000_0000) && (a <= 32'h3fff_ffff);
  endfunction

  initial begin : wb_responder
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    lat = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (!(bus.wb_cyc_o && bus.wb_stb_o)) begin
        wait_cnt = 0;
        lat = $urandom_range(0, 2);
      end else if (wait_cnt < lat) begin
        wait_cnt++;
      end else begin
        log_q.push_back(enc(bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o, bus.wb_dat_o));
        if (bus.wb_we_o) bus.wb_dat_i = $urandom;
        else if (pass_mode) bus.wb_dat_i = pass_rd;
        else if (bus.wb_adr_o == 5'h10) begin
          if (busy_left > 0) begin
            busy_left--;
            bus.wb_dat_i = 32'h0000_0540;
          end else begin
            bus.wb_dat_i = 32'h0000_0040;
          end
        end else if (bus.wb_adr_o == 5'h00) bus.wb_dat_i = rx_word;
        else bus.wb_dat_i = $urandom;
        if (txn_idx == err_at) bus.wb_err_i = 1'b1;
        else bus.wb_ack_i = 1'b1;
        txn_idx++;
        last_ack_cycle = cycle;
        wait_cnt = 0;
      end
    end
  end

  task automatic model(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                       input logic [3:0] st, input int busy, input int eat, input logic [31:0] rx,
                       input logic [31:0] prd);
    int n;
    bit timeout;
    exp_q.delete();
    exp_err = 0;
    exp_rd_valid = 0;
    exp_rd = '0;
    exp_no_wb = 0;
    if (win_b(addr)) begin
      exp_q.push_back(enc(wr, addr[4:0], st, wd));
      exp_err = (eat == 0);
      exp_rd_valid = !wr && !exp_err;
      exp_rd = prd;
    end else if (win_f(addr) && !wr) begin
      exp_q.push_back(enc(1, 5'h04, 4'hf, {8'h03, addr[23:0]}));
      exp_q.push_back(enc(1, 5'h14, 4'hf, 32'd1));
      exp_q.push_back(enc(1, 5'h18, 4'hf, 32'd1));
      exp_q.push_back(enc(1, 5'h10, 4'hf, 32'h540));
      timeout = (busy >= PMAX);
      n = timeout ? PMAX : busy + 1;
      for (int i = 0; i < n; i++) exp_q.push_back(enc(0, 5'h10, 4'hf, 32'h0));
      if (!timeout) exp_q.push_back(enc(0, 5'h00, 4'hf, 32'h0));
      n = exp_q.size();
      if (eat >= 0 && eat < n) begin
        while (exp_q.size() > eat + 1) void'(exp_q.pop_back());
        exp_err = 1;
      end else if (eat == n) begin
        exp_err = 1;
      end
      exp_err = exp_err | timeout;
      exp_q.push_back(enc(1, 5'h18, 4'hf, 32'h0));
      exp_rd_valid = !exp_err;
      exp_rd = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    end else begin
      exp_err = 1;
      exp_no_wb = 1;
    end
  endtask

  task automatic apb_access(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                            input logic [3:0] st, output bit ok, output logic [31:0] rd,
                            output logic err, output int lat, output int unsigned rdy_cycle);
    bus.in_paddr = addr;
    bus.in_pwrite = wr;
    bus.in_pwdata = wd;
    bus.in_pstrb = st;
    bus.in_psel = 1'b1;
    bus.in_penable = 1'b0;
    @(posedge clock);
    #1;
    check_eq("setup_pready", bus.in_pready, 1'b0);
    bus.in_penable = 1'b1;
    ok = 0;
    lat = 0;
    rd = '0;
    err = 1'b0;
    rdy_cycle = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.in_pready) begin
        ok = 1;
        break;
      end
    end
    rd = bus.in_prdata;
    err = bus.in_pslverr;
    rdy_cycle = cycle;
    bus.in_psel = 1'b0;
    bus.in_penable = 1'b0;
    @(posedge clock);
    #1;
    check_eq("pready_width", bus.in_pready, 1'b0);
  endtask

  task automatic run_case(input string name, input logic [31:0] addr, input bit wr,
                          input logic [31:0] wd, input logic [3:0] st, input int busy,
                          input int eat, input logic [31:0] rx, input logic [31:0] prd);
    bit ok;
    logic [31:0] rd;
    logic err;
    int lat;
    int unsigned rdy_cycle;
    pass_mode = win_b(addr);
    busy_left = busy;
    err_at = eat;
    txn_idx = 0;
    rx_word = rx;
    pass_rd = prd;
    log_q.delete();
    model(addr, wr, wd, st, busy, eat, rx, prd);
    apb_access(addr, wr, wd, st, ok, rd, err, lat, rdy_cycle);
    check_eq({name, ".done"}, ok, 1'b1);
    check_eq({name, ".pslverr"}, err, exp_err);
    if (exp_rd_valid) check_eq({name, ".prdata"}, rd, exp_rd);
    check_eq({name, ".wb_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq($sformatf("%s.wb%0d", name, i), log_q[i], exp_q[i]);
    if (pass_mode) check_eq({name, ".ack_to_pready"}, rdy_cycle - last_ack_cycle, 1);
    if (exp_no_wb) check_eq({name, ".err_latency"}, lat, 1);
  endtask

  initial begin : main
    logic [31:0] a;
    int kind;
    int busy;
    int eat;
    bit found;
    reset = 1'b1;
    bus.in_paddr = '0;
    bus.in_psel = 1'b0;
    bus.in_penable = 1'b0;
    bus.in_pwrite = 1'b0;
    bus.in_pwdata = '0;
    bus.in_pstrb = '0;
    pass_mode = 0;
    busy_left = 0;
    err_at = -1;
    txn_idx = 0;
    rx_word = '0;
    pass_rd = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst.pready", bus.in_pready, 1'b0);
    check_eq("rst.prdata", bus.in_prdata, 32'h0);
    check_eq("rst.pslverr", bus.in_pslverr, 1'b0);
    check_eq("rst.cyc", bus.wb_cyc_o, 1'b0);
    check_eq("rst.stb", bus.wb_stb_o, 1'b0);
    check_eq("rst.we", bus.wb_we_o, 1'b0);
    check_eq("rst.adr", bus.wb_adr_o, 5'h0);
    check_eq("rst.dat", bus.wb_dat_o, 32'h0);
    check_eq("rst.sel", bus.wb_sel_o, 4'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_case("xip_basic", 32'h3000_0010, 0, 32'h0, 4'hf, 0, -1, 32'h1122_3344, 32'h0);
    check_eq("xip_basic.swap", exp_rd, 32'h4433_2211);
    run_case("pass_wr_div", 32'h1000_1014, 1, 32'h5, 4'h3, 0, -1, 32'h0, 32'h0);
    run_case("xip_write", 32'h3000_0000, 1, 32'hdead_beef, 4'hf, 0, -1, 32'h0, 32'h0);
    run_case("poll_timeout", 32'h3000_0100, 0, 32'h0, 4'hf, 1000, -1, 32'h0, 32'h0);
    run_case("err_wr_ss", 32'h3000_0200, 0, 32'h0, 4'hf, 0, 2, 32'h0, 32'h0);
    run_case("poll_last_ok", 32'h3000_0300, 0, 32'h0, 4'hf, PMAX - 1, -1, 32'hcafe_f00d, 32'h0);
    run_case("pass_rd_err", 32'h1000_1000, 0, 32'h0, 4'hf, 0, 0, 32'h0, 32'h1234_5678);
    run_case("pass_rd_top", 32'h1000_1fff, 0, 32'h0, 4'h1, 0, -1, 32'h0, 32'h8765_4321);
    run_case("below_b", 32'h1000_0fff, 0, 32'h0, 4'hf, 0, -1, 32'h0, 32'h0);
    run_case("above_b", 32'h1000_2000, 1, 32'h1, 4'hf, 0, -1, 32'h0, 32'h0);
    run_case("below_f", 32'h2fff_ffff, 0, 32'h0, 4'hf, 0, -1, 32'h0, 32'h0);
    run_case("above_f", 32'h4000_0000, 0, 32'h0, 4'hf, 0, -1, 32'h0, 32'h0);
    run_case("f_top", 32'h3fff_fffc, 0, 32'h0, 4'hf, 1, -1, 32'ha5a5_0f0f, 32'h0);

    // reset while polling CTRL, then a clean read
    pass_mode = 0;
    busy_left = 1000;
    err_at = -1;
    txn_idx = 0;
    log_q.delete();
    bus.in_paddr = 32'h3000_0008;
    bus.in_pwrite = 1'b0;
    bus.in_psel = 1'b1;
    bus.in_penable = 1'b0;
    @(posedge clock);
    #1;
    bus.in_penable = 1'b1;
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clock);
      #1;
      if (bus.wb_cyc_o && !bus.wb_we_o && bus.wb_adr_o == 5'h10) begin
        found = 1;
        break;
      end
    end
    check_eq("rst_poll.reached", found, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rst_poll.cyc", bus.wb_cyc_o, 1'b0);
    check_eq("rst_poll.stb", bus.wb_stb_o, 1'b0);
    check_eq("rst_poll.pready", bus.in_pready, 1'b0);
    check_eq("rst_poll.adr", bus.wb_adr_o, 5'h0);
    bus.in_psel = 1'b0;
    bus.in_penable = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_case("after_rst", 32'h3000_0004, 0, 32'h0, 4'hf, 0, -1, 32'h0102_0304, 32'h0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      busy = ($urandom_range(0, 7) == 0) ? PMAX + $urandom_range(0, 2) : $urandom_range(0, 3);
      eat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : -1;
      case (kind)
        0, 1: a = 32'h1000_1000 | ($urandom & 32'h0000_0fff);
        2, 3: a = 32'h3000_0000 | ($urandom & 32'h0fff_ffff);
        default: begin
          a = $urandom;
          while (win_b(a) || win_f(a)) a = $urandom;
        end
      endcase
      run_case($sformatf("rnd%0d", i), a, (kind == 0 || kind == 3 || (kind == 4 && a[0])),
               $urandom, 4'($urandom), busy, eat, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
